axi_burst_arbiter: RTL and testbench

// - Burst-level arbiter sharing the interconnect's master ports between requesters s0 and s1.
// - Independent write and read arbitration, each with its own grant.
// - A grant is held from address request through burst completion:
//   - write: B handshake;
//   - read: last R beat.
// - The interconnect muxes AW/W/B by write_grant and AR/R by read_grant.
// - The interconnect passes back the handshakes of the muxed (granted) channel.

---
 rtl/axi_burst_arbiter.sv | 145 ++++++++++++++
 tb/tb_axi_burst_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_arbiter.sv
// Burst-level arbiter for two requesters sharing the interconnect master port.
// Independent write and read FSMs hold their grants until the burst completes, with an optional watchdog.
module axi_burst_arbiter #(
    parameter bit          FIXED_PRIORITY = 1'b0,
    parameter int unsigned GRANT_TIMEOUT  = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s0_awvalid,
    input  logic       s1_awvalid,
    input  logic       s0_arvalid,
    input  logic       s1_arvalid,
    input  logic       m_awvalid,
    input  logic       m_awready,
    input  logic       m_wvalid,
    input  logic       m_wready,
    input  logic       m_wlast,
    input  logic       m_bvalid,
    input  logic       m_bready,
    input  logic       m_arvalid,
    input  logic       m_arready,
    input  logic       m_rvalid,
    input  logic       m_rready,
    input  logic       m_rlast,
    output logic       write_grant,
    output logic       write_grant_valid,
    output logic       read_grant,
    output logic       read_grant_valid,
    output logic [1:0] timeout_err
);

    localparam int unsigned CW = (GRANT_TIMEOUT != 0) ? $clog2(GRANT_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] CNT_LAST = (GRANT_TIMEOUT != 0) ? CW'(GRANT_TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;

    wstate_t       w_state, w_next;
    rstate_t       r_state, r_next;
    logic          w_ptr, w_ptr_nx, r_ptr, r_ptr_nx;
    logic          w_grant_nx, r_grant_nx;
    logic          wdone, wdone_nx;
    logic          w_to, r_to;
    logic [CW-1:0] w_cnt, w_cnt_nx, r_cnt, r_cnt_nx;
    logic          aw_hs, wl_hs, b_hs, ar_hs, rl_hs;

    // ptr=0 favours s0; a lone requester wins regardless of the pointer
    function automatic logic pick(input logic req0, input logic req1, input logic ptr);
        if (req0 && req1) return FIXED_PRIORITY ? 1'b0 : ptr;
        return req1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            w_state           <= W_IDLE;
            r_state           <= R_IDLE;
            w_ptr             <= 1'b0;
            r_ptr             <= 1'b0;
            wdone             <= 1'b0;
            w_cnt             <= '0;
            r_cnt             <= '0;
            write_grant       <= 1'b0;
            write_grant_valid <= 1'b0;
            read_grant        <= 1'b0;
            read_grant_valid  <= 1'b0;
            timeout_err       <= 2'b00;
        end else begin
            w_state           <= w_next;
            r_state           <= r_next;
            w_ptr             <= w_ptr_nx;
            r_ptr             <= r_ptr_nx;
            wdone             <= wdone_nx;
            w_cnt             <= w_cnt_nx;
            r_cnt             <= r_cnt_nx;
            write_grant       <= w_grant_nx;
            write_grant_valid <= (w_next != W_IDLE);
            read_grant        <= r_grant_nx;
            read_grant_valid  <= (r_next != R_IDLE);
            timeout_err       <= {r_to, w_to};
        end
    end

    always_comb begin
        aw_hs      = m_awvalid && m_awready;
        wl_hs      = m_wvalid && m_wready && m_wlast;
        b_hs       = m_bvalid && m_bready;
        ar_hs      = m_arvalid && m_arready;
        rl_hs      = m_rvalid && m_rready && m_rlast;
        w_next     = w_state;
        r_next     = r_state;
        w_ptr_nx   = w_ptr;
        r_ptr_nx   = r_ptr;
        w_grant_nx = write_grant;
        r_grant_nx = read_grant;
        wdone_nx   = wdone;
        w_to       = 1'b0;
        r_to       = 1'b0;

        case (w_state)
            W_IDLE: if (s0_awvalid || s1_awvalid) begin
                w_next     = W_ADDR;
                w_grant_nx = pick(s0_awvalid, s1_awvalid, w_ptr);
                w_ptr_nx   = ~w_grant_nx;
            end
            // last W beat may arrive before the address; remember it in wdone
            W_ADDR: if (aw_hs) w_next = (wdone || wl_hs) ? W_RESP : W_DATA;
                    else if (wl_hs) wdone_nx = 1'b1;
            W_DATA: if (wl_hs) w_next = W_RESP;
            W_RESP: if (b_hs) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase

        case (r_state)
            R_IDLE: if (s0_arvalid || s1_arvalid) begin
                r_next     = R_ADDR;
                r_grant_nx = pick(s0_arvalid, s1_arvalid, r_ptr);
                r_ptr_nx   = ~r_grant_nx;
            end
            R_ADDR: if (ar_hs) r_next = R_DATA;
            R_DATA: if (rl_hs) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase

        // watchdog: abort a grant stuck in one state for GRANT_TIMEOUT cycles
        if (GRANT_TIMEOUT != 0 && w_state != W_IDLE && w_next == w_state && w_cnt == CNT_LAST) begin
            w_next = W_IDLE;
            w_to   = 1'b1;
        end
        if (GRANT_TIMEOUT != 0 && r_state != R_IDLE && r_next == r_state && r_cnt == CNT_LAST) begin
            r_next = R_IDLE;
            r_to   = 1'b1;
        end
        if (w_next != W_ADDR) wdone_nx = 1'b0;

        if (GRANT_TIMEOUT == 0 || w_next != w_state) w_cnt_nx = '0;
        else if (w_state != W_IDLE && w_cnt != CNT_MAX) w_cnt_nx = w_cnt + CW'(1);
        else w_cnt_nx = w_cnt;

        if (GRANT_TIMEOUT == 0 || r_next != r_state) r_cnt_nx = '0;
        else if (r_state != R_IDLE && r_cnt != CNT_MAX) r_cnt_nx = r_cnt + CW'(1);
        else r_cnt_nx = r_cnt;
    end

endmodule

// File: tb/tb_axi_burst_arbiter.sv
// Bench for axi_burst_arbiter: three instances (round-robin, fixed priority, watchdog=16)
// driven in parallel, checked by vector table, directed sequences and a random run against a burst model.
module tb_axi_burst_arbiter;

    logic clk = 1'b0;
    logic reset;
    logic s0_awvalid, s1_awvalid, s0_arvalid, s1_arvalid;
    logic m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
    logic m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;

    logic       wg[3], wgv[3], rg[3], rgv[3];
    logic [1:0] te[3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        axi_burst_arbiter #(
            .FIXED_PRIORITY (1'(g == 1)),
            .GRANT_TIMEOUT  ((g == 2) ? 32'd16 : 32'd0)
        ) u_dut (
            .clk               (clk),
            .reset             (reset),
            .s0_awvalid        (s0_awvalid),
            .s1_awvalid        (s1_awvalid),
            .s0_arvalid        (s0_arvalid),
            .s1_arvalid        (s1_arvalid),
            .m_awvalid         (m_awvalid),
            .m_awready         (m_awready),
            .m_wvalid          (m_wvalid),
            .m_wready          (m_wready),
            .m_wlast           (m_wlast),
            .m_bvalid          (m_bvalid),
            .m_bready          (m_bready),
            .m_arvalid         (m_arvalid),
            .m_arready         (m_arready),
            .m_rvalid          (m_rvalid),
            .m_rready          (m_rready),
            .m_rlast           (m_rlast),
            .write_grant       (wg[g]),
            .write_grant_valid (wgv[g]),
            .read_grant        (rg[g]),
            .read_grant_valid  (rgv[g]),
            .timeout_err       (te[g])
        );
    end

    // Burst-level model: a channel is busy from grant until completion,
    // tracking whether address and data phases are done plus time spent in the current phase.
    typedef struct packed {
        logic       busy;
        logic       g;
        logic       a;
        logic       d;
        logic       err;
        logic       fav;
        logic [7:0] age;
    } ch_t;

    ch_t wm[3], rm[3];

    function automatic bit fixed_of(input int i); return i == 1; endfunction
    function automatic int tmo_of(input int i);   return (i == 2) ? 16 : 0; endfunction

    function automatic ch_t grant_step(input ch_t c, input logic q0, input logic q1, input bit fixed);
        ch_t n = c;
        if (q0 || q1) begin
            n.g    = (q0 && q1) ? (fixed ? 1'b0 : c.fav) : q1;
            n.fav  = ~n.g;
            n.busy = 1'b1;
            n.a    = 1'b0;
            n.d    = 1'b0;
            n.age  = 8'd0;
        end
        return n;
    endfunction

    function automatic ch_t finish_step(input ch_t n, input bit moved, input bit done, input ch_t c, input int tmo);
        ch_t r = n;
        bit  fin = done;
        if (!moved && tmo > 0 && int'(c.age) == tmo - 1) begin
            fin   = 1'b1;
            r.err = 1'b1;
        end
        if (fin) r.busy = 1'b0;
        else r.age = moved ? 8'd0 : ((c.age == 8'hFF) ? c.age : c.age + 8'd1);
        return r;
    endfunction

    function automatic ch_t wr_step(input ch_t c, input logic rst, input logic q0, input logic q1,
                                    input logic ha, input logic hd, input logic hb, input bit fixed, input int tmo);
        ch_t n = c;
        bit  done = 1'b0;
        int  ph_old, ph_new;
        n.err = 1'b0;
        if (rst) return '0;
        if (!c.busy) return grant_step(n, q0, q1, fixed);
        if (c.a && c.d) done = hb;
        else begin
            if (!c.a && ha) n.a = 1'b1;
            if (!c.d && hd) n.d = 1'b1;
        end
        ph_old = c.a ? (c.d ? 2 : 1) : 0;
        ph_new = n.a ? (n.d ? 2 : 1) : 0;
        return finish_step(n, done || ph_old != ph_new, done, c, tmo);
    endfunction

    function automatic ch_t rd_step(input ch_t c, input logic rst, input logic q0, input logic q1,
                                    input logic ha, input logic hl, input bit fixed, input int tmo);
        ch_t n = c;
        bit  done = 1'b0;
        n.err = 1'b0;
        if (rst) return '0;
        if (!c.busy) return grant_step(n, q0, q1, fixed);
        if (c.a) done = hl;
        else if (ha) n.a = 1'b1;
        return finish_step(n, done || n.a != c.a, done, c, tmo);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            wm[i] <= wr_step(wm[i], reset, s0_awvalid, s1_awvalid, m_awvalid && m_awready,
                             m_wvalid && m_wready && m_wlast, m_bvalid && m_bready, fixed_of(i), tmo_of(i));
            rm[i] <= rd_step(rm[i], reset, s0_arvalid, s1_arvalid, m_arvalid && m_arready,
                             m_rvalid && m_rready && m_rlast, fixed_of(i), tmo_of(i));
        end
    end

    function automatic logic [7:0] mk(input logic [1:0] t, input logic r_g, input logic r_v,
                                      input logic w_g, input logic w_v);
        return {2'b00, t, r_g, r_v, w_g, w_v};
    endfunction

    function automatic logic [7:0] outvec(input int i);
        return mk(te[i], rg[i], rgv[i], wg[i], wgv[i]);
    endfunction

    function automatic logic [7:0] modelvec(input int i);
        return mk({rm[i].err, wm[i].err}, rm[i].g, rm[i].busy, wm[i].g, wm[i].busy);
    endfunction

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d actual=%b expected=%b t=%0t", name, idx, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s0_awvalid = 1'b0; s1_awvalid = 1'b0; s0_arvalid = 1'b0; s1_arvalid = 1'b0;
        m_awvalid  = 1'b0; m_awready  = 1'b0; m_wvalid   = 1'b0; m_wready   = 1'b0; m_wlast = 1'b0;
        m_bvalid   = 1'b0; m_bready   = 1'b0; m_arvalid  = 1'b0; m_arready  = 1'b0;
        m_rvalid   = 1'b0; m_rready   = 1'b0; m_rlast    = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Fields: rst, s0_aw, s1_aw, aw_hs, w_hs, wlast, b_hs, expected write_grant, expected write_grant_valid
    typedef struct packed {
        logic rst, s0, s1, aw, w, wl, b, eg, ev;
    } vec_t;

    vec_t tbl[17];

    initial begin
        reset = 1'b1;
        idle_inputs();

        // s1 burst of 4 beats, then s0 burst with data ahead of address
        tbl[0]  = 9'b1_00_0000_00;
        tbl[1]  = 9'b0_01_0000_11;
        tbl[2]  = 9'b0_00_1000_11;
        tbl[3]  = 9'b0_00_0100_11;
        tbl[4]  = 9'b0_00_0100_11;
        tbl[5]  = 9'b0_00_0100_11;
        tbl[6]  = 9'b0_00_0110_11;
        tbl[7]  = 9'b0_00_0000_11;
        tbl[8]  = 9'b0_00_0001_10;
        tbl[9]  = 9'b0_00_0000_10;
        tbl[10] = 9'b0_10_0000_01;
        tbl[11] = 9'b0_00_0110_01;
        tbl[12] = 9'b0_00_0000_01;
        tbl[13] = 9'b0_00_0000_01;
        tbl[14] = 9'b0_00_1000_01;
        tbl[15] = 9'b0_00_0001_00;
        tbl[16] = 9'b0_00_0000_00;

        for (int r = 0; r < 17; r++) begin
            reset      = tbl[r].rst;
            s0_awvalid = tbl[r].s0;
            s1_awvalid = tbl[r].s1;
            m_awvalid  = tbl[r].aw;
            m_awready  = tbl[r].aw;
            m_wvalid   = tbl[r].w;
            m_wready   = tbl[r].w;
            m_wlast    = tbl[r].wl;
            m_bvalid   = tbl[r].b;
            m_bready   = tbl[r].b;
            step();
            for (int i = 0; i < 3; i++)
                chk($sformatf("table_row%0d", r), i, outvec(i), mk(2'b00, 1'b0, 1'b0, tbl[r].eg, tbl[r].ev));
        end

        // both requesters held, every handshake instant: 3-cycle burst period with 1-cycle bubble
        do_reset();
        s0_awvalid = 1'b1; s1_awvalid = 1'b1;
        m_awvalid = 1'b1; m_awready = 1'b1; m_wvalid = 1'b1; m_wready = 1'b1; m_wlast = 1'b1;
        m_bvalid = 1'b1; m_bready = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            step();
            for (int i = 0; i < 3; i++) begin
                if ((e - 1) % 3 == 0)
                    chk($sformatf("tie_grant_burst%0d", (e - 1) / 3), i, {6'd0, wg[i], wgv[i]},
                        {6'd0, fixed_of(i) ? 1'b0 : 1'((((e - 1) / 3) % 2) != 0), 1'b1});
                else if ((e - 1) % 3 == 2)
                    chk("tie_bubble", i, {7'd0, wgv[i]}, 8'd0);
            end
        end

        // concurrent s0 write and s1 read with an 8-beat read burst
        do_reset();
        s0_awvalid = 1'b1; s1_arvalid = 1'b1;
        step();
        idle_inputs();
        for (int i = 0; i < 3; i++) chk("conc_grant", i, outvec(i), mk(2'b00, 1'b1, 1'b1, 1'b0, 1'b1));
        m_arvalid = 1'b1; m_arready = 1'b1;
        step();
        idle_inputs();
        for (int k = 1; k <= 8; k++) begin
            m_rvalid = 1'b1; m_rready = 1'b1; m_rlast = 1'(k == 8);
            step();
            for (int i = 0; i < 3; i++)
                chk($sformatf("conc_rbeat%0d", k), i, outvec(i), mk(2'b00, 1'b1, 1'(k < 8), 1'b0, 1'b1));
        end
        idle_inputs();
        m_awvalid = 1'b1; m_awready = 1'b1; m_wvalid = 1'b1; m_wready = 1'b1; m_wlast = 1'b1;
        step();
        idle_inputs();
        for (int i = 0; i < 3; i++) chk("conc_wresp", i, outvec(i), mk(2'b00, 1'b1, 1'b0, 1'b0, 1'b1));
        m_bvalid = 1'b1; m_bready = 1'b1;
        step();
        idle_inputs();
        for (int i = 0; i < 3; i++) chk("conc_bdone", i, outvec(i), mk(2'b00, 1'b1, 1'b0, 1'b0, 1'b0));

        // watchdog: AW never accepted on the 16-cycle instance
        do_reset();
        s0_awvalid = 1'b1;
        step();
        idle_inputs();
        m_awvalid = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            step();
            chk($sformatf("wdog_cycle%0d", k), 2, {5'd0, te[2], wgv[2]},
                {5'd0, (k == 16) ? 2'b01 : 2'b00, 1'(k < 16)});
        end
        idle_inputs();
        s0_awvalid = 1'b1; s1_awvalid = 1'b1;
        step();
        idle_inputs();
        chk("wdog_ptr_advance", 2, {6'd0, wg[2], wgv[2]}, 8'b0000_0011);

        // reset while both channels are mid-data
        do_reset();
        s1_awvalid = 1'b1; s1_arvalid = 1'b1;
        step();
        idle_inputs();
        for (int i = 0; i < 3; i++) chk("rst_pre_grant", i, outvec(i), mk(2'b00, 1'b1, 1'b1, 1'b1, 1'b1));
        m_awvalid = 1'b1; m_awready = 1'b1; m_arvalid = 1'b1; m_arready = 1'b1;
        step();
        idle_inputs();
        m_wvalid = 1'b1; m_wready = 1'b1; m_rvalid = 1'b1; m_rready = 1'b1;
        step();
        m_wlast = 1'b1; m_rlast = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle_inputs();
        for (int i = 0; i < 3; i++) chk("rst_mid_burst", i, outvec(i), 8'd0);
        s0_awvalid = 1'b1;
        step();
        idle_inputs();
        for (int i = 0; i < 3; i++) chk("rst_then_idle", i, outvec(i), mk(2'b00, 1'b0, 1'b0, 1'b0, 1'b1));

        // random traffic with periodic stalls long enough to trip the watchdog
        for (int c = 0; c < 4000; c++) begin
            bit stall;
            stall      = (c % 100) >= 60;
            reset      = (c == 0) || ($urandom_range(0, 299) == 0);
            s0_awvalid = 1'($urandom_range(0, 1));
            s1_awvalid = 1'($urandom_range(0, 1));
            s0_arvalid = 1'($urandom_range(0, 1));
            s1_arvalid = 1'($urandom_range(0, 1));
            m_awvalid  = 1'($urandom_range(0, 1));
            m_awready  = !stall && 1'($urandom_range(0, 1));
            m_wvalid   = 1'($urandom_range(0, 1));
            m_wready   = !stall && 1'($urandom_range(0, 1));
            m_wlast    = ($urandom_range(0, 2) == 0);
            m_bvalid   = 1'($urandom_range(0, 1));
            m_bready   = !stall && 1'($urandom_range(0, 1));
            m_arvalid  = 1'($urandom_range(0, 1));
            m_arready  = !stall && 1'($urandom_range(0, 1));
            m_rvalid   = 1'($urandom_range(0, 1));
            m_rready   = !stall && 1'($urandom_range(0, 1));
            m_rlast    = ($urandom_range(0, 3) == 0);
            step();
            for (int i = 0; i < 3; i++) chk("random_vs_model", i, outvec(i), modelvec(i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
